// File: rtl/vlsu_mem_sequencer.sv
// Vector load/store sequencer: splits one vector memory instruction into single-word
// memory transactions. Defining VLSU_MISALIGN_CHK_EN adds a vlsu_err misalignment flag.
module vlsu_mem_sequencer #(
   parameter int ADDR_W = 32,
   parameter int VL_W   = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vlsu_en,
   input  logic              vlsu_load,
   input  logic              vlsu_store,
   input  logic              vlsu_strided,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [31:0]       stride,
   input  logic [VL_W-1:0]   vl,
   input  logic [4:0]        vd_addr,
   output logic              vlsu_ready,
   output logic              busy,
`ifdef VLSU_MISALIGN_CHK_EN
   output logic              vlsu_err,
`endif
   output logic              data_req,
   input  logic              data_gnt,
   output logic [ADDR_W-1:0] data_addr,
   output logic              data_we,
   output logic [3:0]        data_be,
   output logic [31:0]       data_wdata,
   input  logic              data_rvalid,
   input  logic [31:0]       data_rdata,
   output logic [4:0]        vreg_rd_addr,
   input  logic [31:0]       vreg_rd_data,
   output logic              vreg_wr_en,
   output logic [4:0]        vreg_wr_addr,
   output logic [31:0]       vreg_wr_data,
   output logic [3:0]        vreg_wr_be
);

   // Memory handshake: data_req with addr/we/be/wdata stays stable until the cycle
   // data_gnt is high; exactly one data_rvalid then follows, accepted only in RESP.
   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

   state_e              state_q, state_d;
   logic                store_q, store_d;
   logic                strided_q, strided_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   stride_q, stride_d;
   logic [VL_W-1:0]     vl_q, vl_d;
   logic [4:0]          vd_q, vd_d;
   logic [VL_W-1:0]     cnt_q, cnt_d;
   logic                wr_en_q, wr_en_d;
   logic [4:0]          wr_addr_q, wr_addr_d;
   logic [31:0]         wr_data_q, wr_data_d;
   logic [3:0]          wr_be_q, wr_be_d;
`ifdef VLSU_MISALIGN_CHK_EN
   logic                err_q, err_d;
   logic                misalign;
`endif

   logic                start;
   logic [ADDR_W-1:0]   start_addr;
   logic [VL_W:0]       n_xfer;
   logic                last;
   logic [1:0]          lane;
   logic [4:0]          cur_reg;
   logic [3:0]          unit_be;
   logic [3:0]          xfer_be;
   logic [3:0]          lane_mask;
   logic [7:0]          rd_byte;
   logic [7:0]          st_byte;
   logic [ADDR_W-1:0]   addr_inc;

   assign start = vlsu_en & (vlsu_load ^ vlsu_store);

`ifdef VLSU_MISALIGN_CHK_EN
   assign misalign   = ~vlsu_strided & (base_addr[1:0] != 2'b00);
   assign start_addr = base_addr;
`else
   assign start_addr = vlsu_strided ? base_addr : {base_addr[ADDR_W-1:2], 2'b00};
`endif

   // cnt_q counts words for unit-stride and elements for strided access.
   always_comb begin
      n_xfer    = strided_q ? {1'b0, vl_q} : (({1'b0, vl_q}) + (VL_W+1)'(3)) >> 2;
      last      = (({1'b0, cnt_q}) + (VL_W+1)'(1)) == n_xfer;
      lane      = cnt_q[1:0];
      cur_reg   = vd_q + (strided_q ? 5'(cnt_q >> 2) : 5'(cnt_q));
      unit_be   = (last && (vl_q[1:0] != 2'b00)) ? ~(4'hF << vl_q[1:0]) : 4'hF;
      xfer_be   = strided_q ? (4'd1 << addr_q[1:0]) : unit_be;
      lane_mask = strided_q ? (4'd1 << lane) : unit_be;
      rd_byte   = data_rdata[8*addr_q[1:0] +: 8];
      st_byte   = vreg_rd_data[8*lane +: 8];
      addr_inc  = strided_q ? stride_q : ADDR_W'(4);
   end

   always_comb begin
      state_d    = state_q;
      store_d    = store_q;
      strided_d  = strided_q;
      addr_d     = addr_q;
      stride_d   = stride_q;
      vl_d       = vl_q;
      vd_d       = vd_q;
      cnt_d      = cnt_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      wr_be_d    = wr_be_q;
      vlsu_ready = 1'b0;
      data_req   = 1'b0;
`ifdef VLSU_MISALIGN_CHK_EN
      err_d      = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               store_d   = vlsu_store;
               strided_d = vlsu_strided;
               addr_d    = start_addr;
               stride_d  = ADDR_W'($signed(stride));
               vl_d      = vl;
               vd_d      = vd_addr;
               cnt_d     = '0;
               if (vl == '0) begin
                  state_d = DONE;
               end
`ifdef VLSU_MISALIGN_CHK_EN
               else if (misalign) begin
                  state_d = DONE;
                  err_d   = 1'b1;
               end
`endif
               else begin
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            data_req = 1'b1;
            if (data_gnt) state_d = RESP;
         end
         RESP: begin
            if (data_rvalid) begin
               if (!store_q) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = cur_reg;
                  wr_be_d   = lane_mask;
                  wr_data_d = strided_q ? {4{rd_byte}} : data_rdata;
               end
               cnt_d   = cnt_q + VL_W'(1);
               addr_d  = addr_q + addr_inc;
               state_d = last ? DONE : REQ;
            end
         end
         DONE: begin
            vlsu_ready = 1'b1;
            state_d    = IDLE;
`ifdef VLSU_MISALIGN_CHK_EN
            err_d      = 1'b0;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // Request-side outputs are forced to zero outside REQ so idle buses stay quiet.
   always_comb begin
      busy         = (state_q != IDLE);
      data_addr    = data_req ? addr_q : '0;
      data_we      = data_req & store_q;
      data_be      = data_req ? xfer_be : 4'h0;
      vreg_rd_addr = (data_req & store_q) ? cur_reg : 5'd0;
      data_wdata   = (data_req & store_q) ? (strided_q ? {4{st_byte}} : vreg_rd_data) : 32'h0;
      vreg_wr_en   = wr_en_q;
      vreg_wr_addr = wr_addr_q;
      vreg_wr_data = wr_data_q;
      vreg_wr_be   = wr_be_q;
`ifdef VLSU_MISALIGN_CHK_EN
      vlsu_err     = (state_q == DONE) & err_q;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         store_q   <= 1'b0;
         strided_q <= 1'b0;
         addr_q    <= '0;
         stride_q  <= '0;
         vl_q      <= '0;
         vd_q      <= '0;
         cnt_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_be_q   <= '0;
`ifdef VLSU_MISALIGN_CHK_EN
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         store_q   <= store_d;
         strided_q <= strided_d;
         addr_q    <= addr_d;
         stride_q  <= stride_d;
         vl_q      <= vl_d;
         vd_q      <= vd_d;
         cnt_q     <= cnt_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         wr_be_q   <= wr_be_d;
`ifdef VLSU_MISALIGN_CHK_EN
         err_q     <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_vlsu_mem_sequencer.sv
// Bench for vlsu_mem_sequencer: a memory/vreg-file responder plus an element-level
// model of the expected memory requests, vreg writes and completion pulses.
module tb_vlsu_mem_sequencer;
   localparam int ADDR_W = 32;
   localparam int VL_W   = 5;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              vlsu_en = 1'b0;
   logic              vlsu_load = 1'b0;
   logic              vlsu_store = 1'b0;
   logic              vlsu_strided = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [31:0]       stride = '0;
   logic [VL_W-1:0]   vl = '0;
   logic [4:0]        vd_addr = '0;
   logic              vlsu_ready, busy;
   logic              data_req, data_we;
   logic              data_gnt, data_rvalid;
   logic [ADDR_W-1:0] data_addr;
   logic [3:0]        data_be;
   logic [31:0]       data_wdata, data_rdata;
   logic [4:0]        vreg_rd_addr, vreg_wr_addr;
   logic [31:0]       vreg_rd_data, vreg_wr_data;
   logic              vreg_wr_en;
   logic [3:0]        vreg_wr_be;
`ifdef VLSU_MISALIGN_CHK_EN
   logic              vlsu_err;
`endif

   logic [31:0] vrf [32];
   assign vreg_rd_data = vrf[vreg_rd_addr];

   vlsu_mem_sequencer #(.ADDR_W(ADDR_W), .VL_W(VL_W)) dut (
      .clk(clk), .reset(reset), .vlsu_en(vlsu_en), .vlsu_load(vlsu_load),
      .vlsu_store(vlsu_store), .vlsu_strided(vlsu_strided), .base_addr(base_addr),
      .stride(stride), .vl(vl), .vd_addr(vd_addr), .vlsu_ready(vlsu_ready), .busy(busy),
`ifdef VLSU_MISALIGN_CHK_EN
      .vlsu_err(vlsu_err),
`endif
      .data_req(data_req), .data_gnt(data_gnt), .data_addr(data_addr), .data_we(data_we),
      .data_be(data_be), .data_wdata(data_wdata), .data_rvalid(data_rvalid),
      .data_rdata(data_rdata), .vreg_rd_addr(vreg_rd_addr), .vreg_rd_data(vreg_rd_data),
      .vreg_wr_en(vreg_wr_en), .vreg_wr_addr(vreg_wr_addr), .vreg_wr_data(vreg_wr_data),
      .vreg_wr_be(vreg_wr_be)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Expected memory requests {addr, we, be, wdata} and vreg writes {reg, be, data}.
   logic [68:0] exp_req_q[$];
   logic [40:0] exp_vwr_q[$];
   int          exp_ready_cnt = 0;
   bit          exp_err = 0;

   int          stall_cfg = 0;
   int          rsp_lat = 1;
   bit          spur = 0;
   int          hs_cnt = 0;
   int          ready_cnt = 0;
   int          err_cnt = 0;
   logic [31:0] last_addr, last_wdata;
   logic [3:0]  last_be;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
      end
   endtask

   // Memory contents: every byte is its own address xor 0x5A.
   function automatic logic [31:0] mem_rd(input logic [31:0] addr);
      logic [31:0] w, a;
      w = '0;
      for (int b = 0; b < 4; b++) begin
         a = {addr[31:2], 2'b00} + 32'(b);
         w[8*b +: 8] = a[7:0] ^ 8'h5A;
      end
      return w;
   endfunction

   task automatic plan(input bit st, input bit sd, input logic [31:0] base,
                       input logic [31:0] str, input int vlv, input int vdv);
      logic [31:0] a, b, w, t;
      logic [3:0]  be;
      logic [4:0]  r;
      logic [7:0]  byt;
      int          n, ln;
      exp_ready_cnt++;
      exp_err = 0;
      b = base;
      if (vlv == 0) return;
      if (!sd && base[1:0] != 2'b00) begin
`ifdef VLSU_MISALIGN_CHK_EN
         exp_err = 1;
         return;
`else
         b = {base[31:2], 2'b00};
`endif
      end
      if (!sd) begin
         n = (vlv + 3) / 4;
         for (int k = 0; k < n; k++) begin
            a  = b + 32'(4 * k);
            be = (k == n - 1 && vlv % 4 != 0) ? 4'((1 << (vlv % 4)) - 1) : 4'hF;
            r  = 5'((vdv + k) % 32);
            if (st) exp_req_q.push_back({a, 1'b1, be, vrf[r]});
            else begin
               exp_req_q.push_back({a, 1'b0, be, 32'h0});
               exp_vwr_q.push_back({r, be, mem_rd(a)});
            end
         end
      end else begin
         for (int i = 0; i < vlv; i++) begin
            a  = b + 32'(i) * str;
            be = 4'b0001 << a[1:0];
            r  = 5'((vdv + i / 4) % 32);
            ln = i % 4;
            if (st) begin
               t   = vrf[r];
               byt = t[8*ln +: 8];
               exp_req_q.push_back({a, 1'b1, be, {4{byt}}});
            end else begin
               w   = mem_rd(a);
               byt = w[8*a[1:0] +: 8];
               exp_req_q.push_back({a, 1'b0, be, 32'h0});
               exp_vwr_q.push_back({r, 4'(1 << ln), {24'h0, byt} << (8 * ln)});
            end
         end
      end
   endtask

   // Memory responder, vreg file and per-cycle compare against the model queues.
   initial begin : bus
      logic [68:0] e;
      logic [40:0] v;
      logic [31:0] m, pend_addr, prev_addr, prev_wdata;
      logic [3:0]  prev_be;
      bit          pend_we, in_req, prev_stall;
      int          stall_cnt, rsp_wait;
      for (int i = 0; i < 32; i++) vrf[i] = 32'hF0F0_0000 | 32'(i);
      vrf[7] = 32'hDDCC_BBAA;
      data_gnt = 0; data_rvalid = 0; data_rdata = '0;
      in_req = 0; prev_stall = 0; stall_cnt = 0; rsp_wait = 0;
      pend_addr = '0; pend_we = 0; prev_addr = '0; prev_wdata = '0; prev_be = '0;
      forever begin
         @(negedge clk);
         data_rvalid = 0;
         data_rdata  = '0;
         if (rsp_wait > 0) begin
            rsp_wait--;
            if (rsp_wait == 0) begin
               data_rvalid = 1;
               data_rdata  = pend_we ? 32'hDEAD_BEEF : mem_rd(pend_addr);
            end
         end else if (spur) begin
            data_rvalid = 1;
            data_rdata  = 32'h1234_5678;
            spur = 0;
         end
         if (prev_stall) begin
            chk("stall_req_held", data_req, 1);
            chk("stall_addr_stable", data_addr, prev_addr);
            chk("stall_be_stable", data_be, prev_be);
            chk("stall_wdata_stable", data_wdata, prev_wdata);
         end
         data_gnt = 0;
         if (data_req) begin
            chk("busy_during_req", busy, 1);
            if (!in_req) begin
               in_req = 1;
               stall_cnt = stall_cfg;
            end
            if (stall_cnt > 0) stall_cnt--;
            else begin
               data_gnt = 1;
               in_req = 0;
            end
         end
         prev_stall = data_req & !data_gnt;
         prev_addr = data_addr; prev_be = data_be; prev_wdata = data_wdata;
         if (data_req && data_gnt) begin
            chk("req_expected", exp_req_q.size() != 0, 1);
            if (exp_req_q.size() != 0) begin
               e = exp_req_q.pop_front();
               chk("req_addr", data_addr, e[68:37]);
               chk("req_we", data_we, e[36]);
               chk("req_be", data_be, e[35:32]);
               if (e[36]) chk("req_wdata", data_wdata, e[31:0]);
            end
            pend_addr = data_addr;
            pend_we   = data_we;
            rsp_wait  = rsp_lat;
            last_addr = data_addr; last_be = data_be; last_wdata = data_wdata;
            hs_cnt++;
         end
         if (vreg_wr_en) begin
            chk("vwr_expected", exp_vwr_q.size() != 0, 1);
            if (exp_vwr_q.size() != 0) begin
               v = exp_vwr_q.pop_front();
               for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{v[32+b]}};
               chk("vwr_addr", vreg_wr_addr, v[40:36]);
               chk("vwr_be", vreg_wr_be, v[35:32]);
               chk("vwr_data", vreg_wr_data & m, v[31:0] & m);
            end
            for (int b = 0; b < 4; b++)
               if (vreg_wr_be[b]) vrf[vreg_wr_addr][8*b +: 8] = vreg_wr_data[8*b +: 8];
         end
         if (vlsu_ready) begin
            ready_cnt++;
            chk("ready_expected", exp_ready_cnt > 0, 1);
            if (exp_ready_cnt > 0) exp_ready_cnt--;
            chk("req_q_drained_at_ready", exp_req_q.size(), 0);
            chk("vwr_q_drained_at_ready", exp_vwr_q.size(), 0);
`ifdef VLSU_MISALIGN_CHK_EN
            chk("err_at_ready", vlsu_err, exp_err);
            if (vlsu_err) err_cnt++;
`endif
         end
      end
   end

   task automatic do_op(input bit ld, input bit st, input bit sd, input logic [31:0] base,
                        input logic [31:0] str, input int vlv, input int vdv,
                        input bit inj, output int lat);
      int r0;
      r0 = ready_cnt;
      plan(st, sd, base, str, vlv, vdv);
      vlsu_load = ld; vlsu_store = st; vlsu_strided = sd;
      base_addr = base; stride = str; vl = VL_W'(vlv); vd_addr = 5'(vdv);
      vlsu_en = 1;
      lat = 0;
      while (ready_cnt == r0 && lat < 300) begin
         @(negedge clk); #1;
         lat++;
         if (lat == 1) begin
            vlsu_en = 0;
            chk("busy_after_start", busy, 1);
         end
         if (inj && lat == 2) begin
            vlsu_en = 1; vlsu_load = 1; vlsu_store = 0; vl = 5'd5;
         end
         if (inj && lat == 3) vlsu_en = 0;
      end
      chk("ready_within_bound", ready_cnt != r0, 1);
      @(negedge clk); #1;
      chk("busy_low_after_ready", busy, 0);
   endtask

   initial begin : watchdog
      #400000;
      failures++;
      $display("FAIL watchdog time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : main
      int lat, h0, r0, n;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_outputs_zero",
          {vlsu_ready, busy, data_req, data_we, data_be, data_addr, data_wdata, vreg_wr_en}, 0);
      reset = 0;
      @(negedge clk); #1;

      // Unit-stride load vl=10
      h0 = hs_cnt;
      do_op(1, 0, 0, 32'h100, 32'h0, 10, 4, 0, lat);
      chk("ul_transfers", hs_cnt - h0, 3);
      chk("ul_v4", vrf[4], 32'h5958_5B5A);
      chk("ul_v5", vrf[5], 32'h5D5C_5F5E);
      chk("ul_v6_partial", vrf[6], 32'hF0F0_5352);

      // Strided load vl=3, stride 5
      do_op(1, 0, 1, 32'h201, 32'd5, 3, 2, 0, lat);
      chk("sl_v2", vrf[2], 32'hF051_5C5B);

      // Unit-stride store with 3-cycle grant stall and a start pulse while busy
      stall_cfg = 3;
      h0 = hs_cnt;
      do_op(0, 1, 0, 32'h40, 32'h0, 4, 7, 1, lat);
      stall_cfg = 0;
      chk("us_transfers", hs_cnt - h0, 1);
      chk("us_wdata", last_wdata, 32'hDDCC_BBAA);
      chk("us_addr", last_addr, 32'h40);
      chk("us_be", last_be, 4'hF);

      // vl=0: completion without memory traffic
      h0 = hs_cnt;
      do_op(1, 0, 0, 32'h80, 32'h0, 0, 1, 0, lat);
      chk("vl0_ready_latency", lat, 1);
      chk("vl0_no_transfers", hs_cnt - h0, 0);

      // Strided store, negative stride, one grant stall, slower responses
      stall_cfg = 1; rsp_lat = 2;
      do_op(0, 1, 1, 32'h310, 32'hFFFF_FFFD, 5, 30, 0, lat);
      stall_cfg = 0; rsp_lat = 1;
      chk("ss_last_wdata", last_wdata, 32'h1F1F_1F1F);
      chk("ss_last_addr", last_addr, 32'h304);
      chk("ss_last_be", last_be, 4'b0001);

      // Unit-stride load with misaligned base and vd wrap
      h0 = hs_cnt;
      do_op(1, 0, 0, 32'h503, 32'h0, 7, 31, 0, lat);
`ifdef VLSU_MISALIGN_CHK_EN
      chk("mis_no_transfers", hs_cnt - h0, 0);
      h0 = err_cnt;
      do_op(1, 0, 0, 32'h102, 32'h0, 4, 3, 0, lat);
      chk("mis102_err_pulse", err_cnt - h0, 1);
      chk("mis102_latency", lat, 1);
`else
      chk("wrap_transfers", hs_cnt - h0, 2);
      chk("wrap_v0", vrf[0], 32'hF05C_5F5E);
`endif

      // Illegal start (load and store both set) and stray rvalid while idle
      r0 = ready_cnt;
      vlsu_load = 1; vlsu_store = 1; vl = 5'd4; vlsu_en = 1;
      @(negedge clk); #1;
      vlsu_en = 0; vlsu_store = 0;
      chk("illegal_start_busy", busy, 0);
      spur = 1;
      repeat (3) @(negedge clk);
      #1;
      chk("idle_no_ready", ready_cnt - r0, 0);

      // Reset while the 2nd transfer waits for its response
      rsp_lat = 2;
      h0 = hs_cnt; r0 = ready_cnt;
      plan(0, 0, 32'h600, 32'h0, 12, 10);
      vlsu_load = 1; vlsu_store = 0; vlsu_strided = 0;
      base_addr = 32'h600; vl = 5'd12; vd_addr = 5'd10; vlsu_en = 1;
      n = 0;
      @(negedge clk); #1;
      vlsu_en = 0;
      while (hs_cnt - h0 < 2 && n < 50) begin
         @(negedge clk); #1;
         n++;
      end
      chk("rst_two_transfers", hs_cnt - h0, 2);
      @(negedge clk); #1;
      reset = 1;
      @(negedge clk); #1;
      reset = 0;
      repeat (3) @(negedge clk);
      #1;
      rsp_lat = 1;
      chk("rst_busy_low", busy, 0);
      chk("rst_no_ready", ready_cnt - r0, 0);
      chk("rst_req_left", exp_req_q.size(), 1);
      chk("rst_vwr_left", exp_vwr_q.size(), 2);
      chk("rst_v11_untouched", vrf[11], 32'hF0F0_000B);
      exp_req_q.delete();
      exp_vwr_q.delete();
      exp_ready_cnt = 0;

      // Fresh strided load after the reset
      h0 = hs_cnt;
      do_op(1, 0, 1, 32'h700, 32'd4, 6, 12, 0, lat);
      chk("post_rst_transfers", hs_cnt - h0, 6);
      chk("post_rst_v13", vrf[13], 32'hF0F0_4E4A);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
